// File: rtl/dadda_multiplier_32_if.sv
// Operand/product bundle for the 16x16 unsigned Dadda multiplier.
// The master drives the operands and the slave returns the registered product.
interface dadda_multiplier_32_if;
   logic [15:0] in0;
   logic [15:0] in1;
   logic [31:0] product;

   modport master (output in0, output in1, input product);
   modport slave  (input in0, input in1, output product);
endinterface

// File: rtl/dadda_multiplier_32.sv
// 16x16 unsigned multiplier: AND-array partial products, Dadda reduction
// (16->13->9->6->4->3->2) built from FA/HA cells, a carry-propagate adder and an output register.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module half_adder (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b;
   assign cout = a & b;
endmodule

module dadda_multiplier_32 (
   input  logic                  clk,
   input  logic                  rst,
   dadda_multiplier_32_if.slave  bus
);
   localparam int STAGES = 6;

   function automatic int stage_target(input int stage);
      case (stage)
         0:       return 13;
         1:       return 9;
         2:       return 6;
         3:       return 4;
         4:       return 3;
         default: return 2;
      endcase
   endfunction

   // kind 0: column height entering the stage, 1: full adders, 2: half adders used there.
   function automatic int dadda_info(input int stage, input int col, input int kind);
      int h   [0:31];
      int nh  [0:31];
      int fa  [0:31];
      int ha  [0:31];
      int cin;
      int ex;
      if (col < 0 || col > 31) return 0;
      for (int c = 0; c < 32; c++) begin
         h[c] = (c <= 30) ? (((c < 30 - c) ? c : 30 - c) + 1) : 0;
      end
      for (int s = 0; s <= stage; s++) begin
         if (kind == 0 && s == stage) return h[col];
         for (int c = 0; c < 32; c++) begin
            cin = (c > 0) ? fa[c-1] + ha[c-1] : 0;
            ex  = h[c] + cin - stage_target(s);
            if (ex > 0) begin
               fa[c] = ex / 2;
               ha[c] = ex % 2;
            end else begin
               fa[c] = 0;
               ha[c] = 0;
            end
            nh[c] = h[c] - 2 * fa[c] - ha[c] + cin;
         end
         if (s == stage) return (kind == 1) ? fa[col] : ha[col];
         for (int c = 0; c < 32; c++) h[c] = nh[c];
      end
      return 0;
   endfunction

   logic lvl_s [0:STAGES][0:31][0:15];
   logic fs_s  [0:STAGES-1][0:31][0:15];
   logic fc_s  [0:STAGES-1][0:31][0:15];
   logic hs_s  [0:STAGES-1][0:31];
   logic hc_s  [0:STAGES-1][0:31];
   logic [31:0] row_a_s;
   logic [31:0] row_b_s;
   logic [31:0] sum_s;
   logic [31:0] product_r;

   genvar s, c, k, i;

   // Partial product pp[i][j] = in0[j] & in1[i] lands in column i+j.
   generate
      for (c = 0; c < 32; c++) begin : g_pp_col
         localparam int H0 = dadda_info(0, c, 0);
         localparam int LO = (c > 15) ? c - 15 : 0;
         for (k = 0; k < 16; k++) begin : g_pp_bit
            if (k < H0) begin : g_pp
               assign lvl_s[0][c][k] = bus.in0[c-(k+LO)] & bus.in1[k+LO];
            end else begin : g_zero
               assign lvl_s[0][c][k] = 1'b0;
            end
         end
      end
   endgenerate

   generate
      for (s = 0; s < STAGES; s++) begin : g_stage
         for (c = 0; c < 32; c++) begin : g_col
            localparam int FA   = dadda_info(s, c, 1);
            localparam int HA   = dadda_info(s, c, 2);
            localparam int FAP  = dadda_info(s, c - 1, 1);
            localparam int HAP  = dadda_info(s, c - 1, 2);
            localparam int NH   = dadda_info(s + 1, c, 0);
            localparam int BASE = FA + HA + FAP + HAP;

            for (i = 0; i < 16; i++) begin : g_fa
               if (i < FA) begin : g_cell
                  full_adder u_fa (
                     .a    (lvl_s[s][c][3*i]),
                     .b    (lvl_s[s][c][3*i+1]),
                     .cin  (lvl_s[s][c][3*i+2]),
                     .sum  (fs_s[s][c][i]),
                     .cout (fc_s[s][c][i])
                  );
               end else begin : g_none
                  assign fs_s[s][c][i] = 1'b0;
                  assign fc_s[s][c][i] = 1'b0;
               end
            end

            if (HA > 0) begin : g_ha
               half_adder u_ha (
                  .a    (lvl_s[s][c][3*FA]),
                  .b    (lvl_s[s][c][3*FA+1]),
                  .sum  (hs_s[s][c]),
                  .cout (hc_s[s][c])
               );
            end else begin : g_no_ha
               assign hs_s[s][c] = 1'b0;
               assign hc_s[s][c] = 1'b0;
            end

            // Next column: own sums, then carries from column c-1, then untouched bits.
            for (k = 0; k < 16; k++) begin : g_next
               if (k < FA) begin : g_fsum
                  assign lvl_s[s+1][c][k] = fs_s[s][c][k];
               end else if (k < FA + HA) begin : g_hsum
                  assign lvl_s[s+1][c][k] = hs_s[s][c];
               end else if (k < FA + HA + FAP) begin : g_fcar
                  assign lvl_s[s+1][c][k] = fc_s[s][c-1][k-FA-HA];
               end else if (k < BASE) begin : g_hcar
                  assign lvl_s[s+1][c][k] = hc_s[s][c-1];
               end else if (k < NH) begin : g_pass
                  assign lvl_s[s+1][c][k] = lvl_s[s][c][3*FA+2*HA+k-BASE];
               end else begin : g_zero
                  assign lvl_s[s+1][c][k] = 1'b0;
               end
            end
         end
      end
   endgenerate

   generate
      for (c = 0; c < 32; c++) begin : g_rows
         assign row_a_s[c] = lvl_s[STAGES][c][0];
         assign row_b_s[c] = lvl_s[STAGES][c][1];
      end
   endgenerate

   // Carry out of bit 31 cannot occur since the product fits in 32 bits.
   assign sum_s = row_a_s + row_b_s;

   // Output register with synchronous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         product_r <= 32'h0000_0000;
      end else begin
         product_r <= sum_s;
      end
   end

   assign bus.product = product_r;
endmodule

// File: tb/tb_dadda_multiplier_32.sv
// Scoreboard bench: the driver queues the expected product per cycle, the monitor checks
// it one edge later.
module tb_dadda_multiplier_32;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   compared   = 0;
   int   mismatched = 0;
   logic [31:0] exp_q [$];
   int          tag_q [$];

   dadda_multiplier_32_if bus ();

   dadda_multiplier_32 dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic r, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp, input int tag);
      @(negedge clk);
      rst     = r;
      bus.in0 = a;
      bus.in1 = b;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
   endtask

   // Monitor: each edge presents the result for the entry queued before it.
   initial begin
      logic [31:0] e;
      int          t;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            compared++;
            if (bus.product !== e) begin
               mismatched++;
               $display("FAIL vec%0d: product=%h expected=%h", t, bus.product, e);
            end
         end
      end
   end

   logic [15:0] va [0:9];
   logic [15:0] vb [0:9];
   logic [31:0] ve [0:9];

   initial begin
      logic [15:0] a;
      logic [15:0] b;
      logic        r;
      va[0] = 16'd3;     vb[0] = 16'd2;     ve[0] = 32'd6;
      va[1] = 16'd15;    vb[1] = 16'd2;     ve[1] = 32'd30;
      va[2] = 16'd15;    vb[2] = 16'd5;     ve[2] = 32'd75;
      va[3] = 16'd10;    vb[3] = 16'd20;    ve[3] = 32'd200;
      va[4] = 16'd65535; vb[4] = 16'd20;    ve[4] = 32'd1310700;
      va[5] = 16'd32766; vb[5] = 16'd20;    ve[5] = 32'd655320;
      va[6] = 16'd32766; vb[6] = 16'd65535; ve[6] = 32'd2147319810;
      va[7] = 16'd32766; vb[7] = 16'd10;    ve[7] = 32'd327660;
      va[8] = 16'd0;     vb[8] = 16'd65535; ve[8] = 32'd0;
      va[9] = 16'd1;     vb[9] = 16'd43981; ve[9] = 32'd43981;
      bus.in0 = 16'hFFFF;
      bus.in1 = 16'hFFFF;

      drive(1'b1, 16'hFFFF, 16'hFFFF, 32'd0, 100);
      drive(1'b1, 16'hFFFF, 16'hFFFF, 32'd0, 101);
      drive(1'b0, 16'hFFFF, 16'hFFFF, 32'd4294836225, 102);
      for (int n = 0; n < 10; n++) drive(1'b0, va[n], vb[n], ve[n], n);
      drive(1'b0, 16'd65535, 16'd0, 32'd0, 110);
      drive(1'b0, 16'd43981, 16'd1, 32'd43981, 111);
      drive(1'b0, 16'd100, 16'd200, 32'd20000, 120);
      drive(1'b1, 16'd7, 16'd9, 32'd0, 121);
      drive(1'b0, 16'd7, 16'd9, 32'd63, 122);

      for (int n = 0; n < 10000; n++) begin
         a = 16'($urandom_range(0, 65535));
         b = 16'($urandom_range(0, 65535));
         r = ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0;
         drive(r, a, b, r ? 32'd0 : ({16'd0, a} * {16'd0, b}), 1000);
      end
      @(negedge clk);
      rst = 1'b0;

      for (int n = 0; n < 10 && exp_q.size() > 0; n++) @(negedge clk);
      if (exp_q.size() > 0) begin
         mismatched++;
         $display("FAIL drain: pending=%0d expected=0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/dadda_multiplier_32.md
Name: dadda_multiplier_32

Overview:
- Unsigned 16x16-bit multiplier producing a 32-bit product.
- Multiplies with a Dadda partial-product reduction tree followed by a final carry-propagate adder.
- Output is registered: one clock of latency.
- Used as an arithmetic datapath leaf wherever a full-precision unsigned product is needed.

Parameters:
- None. Operand width is fixed at 16 bits and product width at 32 bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in0  input  16  multiplicand, unsigned
- in1  input  16  multiplier, unsigned
- product  output  32  registered unsigned product in0*in1

Behaviour:
- Reset:
  - rst is sampled only on the rising edge of clk.
  - When rst=1 at an edge, product becomes 32'h0000_0000.
  - While rst is held high, product stays 0 regardless of inputs.
- Latency:
  - At each rising edge with rst=0, product <= in0*in1, computed from the in0/in1 values present just before that edge.
  - Exactly 1 cycle of latency; a new operand pair is accepted every cycle; no handshake and no stall.
- Reset mid-operation:
  - A rst=1 edge discards the pending result.
  - The first edge with rst=0 afterwards loads the product of the inputs current at that edge.
- Arithmetic:
  - Full-precision unsigned product; 0 <= product <= 65535*65535 = 32'hFFFE_0001.
  - No overflow and no truncation is possible.
- Partial products: pp[i][j] = in0[j] & in1[i] for i,j in 0..15 (256 AND terms), placed in column i+j.
- Dadda reduction:
  - Maximum column height goes through the sequence 16 -> 13 -> 9 -> 6 -> 4 -> 3 -> 2.
  - Each stage uses only as many full adders (3:2) and half adders (2:2) as needed to bring every column to the stage target height.
  - Carries move to column+1 of the next stage.
- Final adder:
  - The two remaining rows are summed by a 32-bit carry-propagate adder.
  - The carry-out of bit 31 is provably 0 and is dropped.
- Implementation constraints:
  - The whole tree plus the final adder is combinational between the input pins and the output register.
  - No behavioural '*' operator is allowed in the datapath.
  - Full-adder and half-adder cells are instantiated, either explicitly or via generate.
- Boundary conditions:
  - Either operand 0 -> product 0.
  - Operand 1 -> product equals the other operand, zero-extended.
  - Both operands 16'hFFFF -> 32'hFFFE_0001.
- No X propagation on product after the first reset edge, provided the inputs are known.

Test Plan:
- rst=1 for 2 cycles with in0=16'hFFFF, in1=16'hFFFF -> product=0 throughout. Release rst -> product=4294836225 one edge later.
- Back-to-back pairs applied one per cycle:
  - (3,2) -> 6
  - (15,2) -> 30
  - (15,5) -> 75
  - (10,20) -> 200
  - Each result appears exactly one edge after its pair is applied.
- Large and corner operands:
  - (65535,20) -> 1310700
  - (32766,20) -> 655320
  - (32766,65535) -> 2147319810
  - (32766,10) -> 327660
  - (0,65535) -> 0
  - (1,43981) -> 43981
- Assert rst for one cycle between two valid operand pairs -> product=0 on that edge, then resumes with the correct product on the next edge.
- Randomized sweep, at least 10000 pairs, scoreboarded against a reference product delayed by 1 cycle -> zero mismatches.
